// File: rtl/rl02_pkg.sv
// rl02_pkg: shared RL02 header constants, FSM states and serial CRC-16 step
package rl02_pkg;
  localparam logic [15:0] RL02_CRC_POLY = 16'hA001;
  localparam int SECTOR_W = 6;
  localparam int HEAD_BIT = 6;
  localparam int CYL_LSB  = 7;
  localparam int CYL_W    = 9;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HUNT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return (crc >> 1) ^ ((crc[0] ^ b) ? RL02_CRC_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/rl02_crc16_serial.sv
// rl02_crc16_serial: LSB-first serial CRC-16 (poly 0xA001)
// Ports: clk_in/rst_in (async active-low), clear loads INIT, en advances one bit, crc = register.
module rl02_crc16_serial
  import rl02_pkg::*;
#(
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);
  logic [15:0] r_crc;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_crc <= 16'h0000;
    else if (clear) r_crc <= INIT;
    else if (en) r_crc <= crc16_step(r_crc, bit_in);
  end
  assign crc = r_crc;
endmodule

// File: rtl/rl02_header_deser.sv
// rl02_header_deser: RL02 sector header sync hunt, 48-bit deserializer and CRC check
// Ports: clk_in/rst_in (async active-low); bit_in/bit_valid_in decoded bit stream;
// sector_in raw active-low sector pulse; busy_out, hdr_valid_out/hdr_err_out pulses,
// crc_ok_out and cyl/head/sector fields held from the last captured header.
module rl02_header_deser
  import rl02_pkg::*;
#(
  parameter int          PREAMBLE_MIN = 16,
  parameter int          HUNT_TIMEOUT = 1024,
  parameter logic [15:0] CRC_INIT     = 16'h0000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             bit_in,
  input  logic             bit_valid_in,
  input  logic             sector_in,
  output logic             busy_out,
  output logic             hdr_valid_out,
  output logic             crc_ok_out,
  output logic             hdr_err_out,
  output logic [CYL_W-1:0] cyl_out,
  output logic             head_out,
  output logic [SECTOR_W-1:0] sector_out
);
  localparam int ZW = $clog2(PREAMBLE_MIN + 1);
  localparam int TW = $clog2(HUNT_TIMEOUT + 1);
  localparam logic [ZW-1:0] ZMAX  = ZW'(PREAMBLE_MIN);
  localparam logic [TW-1:0] TLAST = TW'(HUNT_TIMEOUT - 1);
  state_t r_state, w_next;
  logic r_sec_s1, r_sec_s2, r_sec_d;
  logic [ZW-1:0] r_zero_cnt;
  logic [TW-1:0] r_strobe_cnt;
  logic [5:0] r_bit_cnt;
  logic [47:0] r_sr;
  logic r_hdr_valid, r_hdr_err, r_crc_ok, r_head;
  logic [CYL_W-1:0] r_cyl;
  logic [SECTOR_W-1:0] r_sector;
  logic w_start, w_hunt_clr, w_sync, w_timeout, w_shift, w_done, w_crc_match;
  logic [15:0] w_crc;
  // Sector pulse is asynchronous; preset high so reset release never looks like an edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) {r_sec_s1, r_sec_s2, r_sec_d} <= 3'b111;
    else {r_sec_s1, r_sec_s2, r_sec_d} <= {sector_in, r_sec_s1, r_sec_s2};
  end
  assign w_start = r_sec_d & ~r_sec_s2;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // A new sector edge always wins: it aborts HUNT/SHIFT and re-arms the hunt.
  always_comb begin
    w_next     = r_state;
    w_hunt_clr = 1'b0;
    w_sync     = 1'b0;
    w_timeout  = 1'b0;
    w_shift    = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_next     = S_HUNT;
        w_hunt_clr = 1'b1;
      end
      S_HUNT: if (w_start) w_hunt_clr = 1'b1;
        else if (bit_valid_in) begin
          if (bit_in && r_zero_cnt >= ZMAX) begin
            w_sync = 1'b1;
            w_next = S_SHIFT;
          end else if (r_strobe_cnt == TLAST) begin
            w_timeout = 1'b1;
            w_next    = S_IDLE;
          end
        end
      S_SHIFT: if (w_start) begin
        w_next     = S_HUNT;
        w_hunt_clr = 1'b1;
      end else if (bit_valid_in) begin
        w_shift = 1'b1;
        w_next  = (r_bit_cnt == 6'd47) ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        w_next     = w_start ? S_HUNT : S_IDLE;
        w_hunt_clr = w_start;
      end
      default: w_next = S_IDLE;
    endcase
  end
  assign w_done      = (r_state == S_DONE);
  assign w_crc_match = (r_sr[47:32] == w_crc);
  rl02_crc16_serial #(.INIT(CRC_INIT)) u_crc (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (w_sync | w_hunt_clr),
    .en     (w_shift & (r_bit_cnt < 6'd32)),
    .bit_in (bit_in),
    .crc    (w_crc)
  );
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_zero_cnt   <= '0;
      r_strobe_cnt <= '0;
      r_bit_cnt    <= '0;
      r_sr         <= '0;
      r_hdr_valid  <= 1'b0;
      r_hdr_err    <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_cyl        <= '0;
      r_head       <= 1'b0;
      r_sector     <= '0;
    end else begin
      if (w_hunt_clr) begin
        r_zero_cnt   <= '0;
        r_strobe_cnt <= '0;
      end else if (r_state == S_HUNT && bit_valid_in) begin
        r_strobe_cnt <= r_strobe_cnt + 1'b1;
        r_zero_cnt   <= bit_in ? '0 : (r_zero_cnt == ZMAX ? ZMAX : r_zero_cnt + 1'b1);
      end
      if (w_sync) r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + 1'b1;
      // Right shift: the first received bit ends up at bit 0 (word1 LSB).
      if (w_shift) r_sr <= {bit_in, r_sr[47:1]};
      r_hdr_valid <= w_done;
      r_hdr_err   <= w_timeout | (w_done & ~w_crc_match);
      if (w_done) begin
        r_crc_ok <= w_crc_match;
        r_cyl    <= r_sr[CYL_LSB +: CYL_W];
        r_head   <= r_sr[HEAD_BIT];
        r_sector <= r_sr[SECTOR_W-1:0];
      end
    end
  end
  assign busy_out      = (r_state == S_HUNT) || (r_state == S_SHIFT);
  assign hdr_valid_out = r_hdr_valid;
  assign hdr_err_out   = r_hdr_err;
  assign crc_ok_out    = r_crc_ok;
  assign cyl_out       = r_cyl;
  assign head_out      = r_head;
  assign sector_out    = r_sector;
endmodule

// File: tb/tb_rl02_header_deser.sv
// tb_rl02_header_deser: directed and randomized header streams against a long-division CRC model
module tb_rl02_header_deser;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid_in = 1'b0;
  logic sector_in = 1'b1;
  logic busy_out, hdr_valid_out, crc_ok_out, hdr_err_out, head_out;
  logic [8:0] cyl_out;
  logic [5:0] sector_out;
  int total = 0;
  int bad = 0;
  int vcount = 0;
  int ecount = 0;
  logic [15:0] last_w1;
  logic last_ok;

  rl02_header_deser dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .bit_in        (bit_in),
    .bit_valid_in  (bit_valid_in),
    .sector_in     (sector_in),
    .busy_out      (busy_out),
    .hdr_valid_out (hdr_valid_out),
    .crc_ok_out    (crc_ok_out),
    .hdr_err_out   (hdr_err_out),
    .cyl_out       (cyl_out),
    .head_out      (head_out),
    .sector_out    (sector_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (hdr_valid_out) vcount++;
    if (hdr_err_out) ecount++;
  end

  // CRC-16/ARC as polynomial long division: reflected 0xA001 serial == 0x8005
  // division of the bit sequence taken in arrival order, with the remainder reversed.
  function automatic logic [15:0] model_crc(input logic [15:0] w1, input logic [15:0] w2);
    logic [47:0] d;
    logic [15:0] r;
    d = '0;
    for (int i = 0; i < 32; i++) d[47-i] = (i < 16) ? w1[i] : w2[i-16];
    for (int k = 47; k >= 16; k--) if (d[k]) d[k-:17] = d[k-:17] ^ 17'h18005;
    for (int i = 0; i < 16; i++) r[i] = d[15-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) tick();
    bit_in = b;
    bit_valid_in = 1'b1;
    tick();
    bit_valid_in = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic sector_edge();
    sector_in = 1'b0;
    repeat (3) tick();
    sector_in = 1'b1;
    repeat (2) tick();
  endtask

  task automatic check_fields(input string tag, input logic [15:0] w1, input logic ok);
    chk({tag, "_cyl"}, 32'(cyl_out), 32'(w1 / 128));
    chk({tag, "_head"}, 32'(head_out), 32'((w1 / 64) % 2));
    chk({tag, "_sector"}, 32'(sector_out), 32'(w1 % 64));
    chk({tag, "_crc_ok"}, 32'(crc_ok_out), 32'(ok));
  endtask

  task automatic send_words(input int npre, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input int maxgap, input int nbits);
    logic [47:0] s;
    s = {w3, w2, w1};
    for (int i = 0; i < npre; i++) send_bit(1'b0, $urandom_range(0, maxgap));
    send_bit(1'b1, $urandom_range(0, maxgap));
    for (int i = 0; i < nbits; i++) send_bit(s[i], $urandom_range(0, maxgap));
  endtask

  task automatic run_hdr(input string tag, input int npre, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3, input int maxgap);
    int v0, e0;
    logic ok;
    ok = (w3 == model_crc(w1, w2));
    v0 = vcount;
    e0 = ecount;
    send_words(npre, w1, w2, w3, maxgap, 48);
    chk({tag, "_early_valid"}, 32'(hdr_valid_out), 0);
    chk({tag, "_busy_done"}, 32'(busy_out), 0);
    tick();
    chk({tag, "_valid"}, 32'(hdr_valid_out), 1);
    chk({tag, "_err"}, 32'(hdr_err_out), 32'(!ok));
    check_fields(tag, w1, ok);
    tick();
    chk({tag, "_valid_end"}, 32'(hdr_valid_out), 0);
    chk({tag, "_err_end"}, 32'(hdr_err_out), 0);
    chk({tag, "_nvalid"}, 32'(vcount - v0), 1);
    chk({tag, "_nerr"}, 32'(ecount - e0), 32'(!ok));
    last_w1 = w1;
    last_ok = ok;
  endtask

  initial begin
    logic [15:0] w1, w2, c;
    int e0, v0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_valid", 32'(hdr_valid_out), 0);
    chk("rst_err", 32'(hdr_err_out), 0);
    check_fields("rst", 16'h0000, 1'b0);
    rst_in = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 32'(busy_out), 0);

    sector_edge();
    chk("hunt_busy", 32'(busy_out), 1);
    run_hdr("clean", 46, 16'h01C5, 16'h0000, model_crc(16'h01C5, 16'h0000), 0);

    sector_edge();
    run_hdr("badcrc", 46, 16'h01C5, 16'h0000, model_crc(16'h01C5, 16'h0000) ^ 16'h0001, 0);

    sector_edge();
    v0 = vcount;
    send_words(16, 16'hABCD, 16'h1234, 16'h5555, 0, 20);
    sector_edge();
    chk("abort_nvalid", 32'(vcount - v0), 0);
    chk("abort_busy", 32'(busy_out), 1);
    run_hdr("abort", 16, 16'h0000, 16'h0000, model_crc(16'h0000, 16'h0000), 0);

    sector_edge();
    for (int i = 0; i < 10; i++) send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    chk("short_busy", 32'(busy_out), 1);
    run_hdr("short", 20, 16'hFFBF, 16'h0000, model_crc(16'hFFBF, 16'h0000), 0);

    sector_edge();
    send_words(16, 16'h4321, 16'h8765, 16'h0000, 0, 30);
    rst_in = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_out), 0);
    chk("midrst_valid", 32'(hdr_valid_out), 0);
    check_fields("midrst", 16'h0000, 1'b0);
    repeat (3) tick();
    rst_in = 1'b1;
    tick();
    chk("postrst_busy", 32'(busy_out), 0);
    sector_edge();
    run_hdr("postrst", 16, 16'h4321, 16'h8765, model_crc(16'h4321, 16'h8765), 0);

    for (int n = 0; n < 8; n++) begin
      w1 = 16'($urandom);
      w2 = 16'($urandom);
      c = model_crc(w1, w2);
      if ($urandom_range(0, 2) == 0) c = c ^ (16'h0001 << $urandom_range(0, 15));
      sector_edge();
      run_hdr("rand", $urandom_range(16, 40), w1, w2, c, 2);
    end

    sector_edge();
    e0 = ecount;
    v0 = vcount;
    for (int i = 0; i < 1023; i++) send_bit(1'(i % 8 == 7), 0);
    chk("tmo_early_err", 32'(hdr_err_out), 0);
    chk("tmo_early_busy", 32'(busy_out), 1);
    send_bit(1'b1, 0);
    chk("tmo_err", 32'(hdr_err_out), 1);
    chk("tmo_busy", 32'(busy_out), 0);
    tick();
    chk("tmo_err_end", 32'(hdr_err_out), 0);
    chk("tmo_nerr", 32'(ecount - e0), 1);
    chk("tmo_nvalid", 32'(vcount - v0), 0);
    check_fields("tmo", last_w1, last_ok);
    send_bit(1'b1, 0);
    chk("tmo_idle_busy", 32'(busy_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rl02_header_deser.md
Name: rl02_header_deser

Overview:
- Downstream of the MFM decode stage in the RL02 controller.
- Consumes decoded data bits (one strobe per bit) and hunts for the sync bit after the all-zero preamble.
- Deserializes the three 16-bit header words (header, zero word, CRC) and checks CRC-16.
- Presents cylinder/head/sector plus status to the seek/sector-match logic.

Parameters:
PREAMBLE_MIN, 16, minimum consecutive zero bits required before a 1 is accepted as sync
HUNT_TIMEOUT, 1024, bit strobes allowed in HUNT without sync before abort
CRC_INIT, 16'h0000, CRC-16 register initial value

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-low reset
bit_in  in  1  decoded data bit, qualified by bit_valid_in
bit_valid_in  in  1  one-cycle strobe, one per decoded data bit
sector_in  in  1  raw drive sector pulse, active low, asynchronous to clk_in
busy_out  out  1  high in HUNT or SHIFT
hdr_valid_out  out  1  one-cycle pulse: header captured, fields and status updated
crc_ok_out  out  1  CRC of last header matched (held)
hdr_err_out  out  1  one-cycle pulse: hunt timeout or CRC mismatch
cyl_out  out  9  cylinder, word1[15:7] (held)
head_out  out  1  head, word1[6] (held)
sector_out  out  6  sector, word1[5:0] (held)

Behaviour:
- Reset (rst_in low, async): state IDLE; all outputs 0; zero counter, bit counter, shift register and CRC cleared; sector synchronizer preset to 1 (inactive).
- sector_in passes through a 2-FF synchronizer. Start event = synchronized falling edge (1->0); one cycle of edge detect.
- States:
  - IDLE: on start -> HUNT, clear zero count and strobe count.
  - HUNT: each strobe increments strobe count.
    - bit 0: zero count++ (saturates at PREAMBLE_MIN).
    - bit 1 with zero count >= PREAMBLE_MIN: sync; -> SHIFT, bit count=0, CRC=CRC_INIT. The sync bit is not data.
    - bit 1 with zero count < PREAMBLE_MIN: zero count=0, stay in HUNT.
    - Strobe count reaches HUNT_TIMEOUT: hdr_err_out pulse, -> IDLE.
  - SHIFT: each strobe shifts bit_in into the 48-bit shift register, LSB-first per word (first bit received = word1 bit0).
    - Bits 0-31 are also fed through serial CRC-16, reflected polynomial 0xA001 (x^16+x^15+x^2+1), LSB-first: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? 16'hA001 : 0).
    - On the 48th strobe -> DONE.
  - DONE, one cycle:
    - Latch cyl/head/sector from word1.
    - crc_ok_out = (word3 == CRC register).
    - hdr_valid_out pulse.
    - hdr_err_out pulse additionally if the CRC mismatches.
    - -> IDLE.
- Latency: hdr_valid_out asserts exactly 1 cycle after the clock that samples the 48th data strobe.
- Word2 is included in the CRC but not otherwise checked.
- Start event while in HUNT/SHIFT: abort, no pulses, restart HUNT (counters and CRC cleared). Start in DONE is honoured the next cycle.
- bit_valid_in is ignored in IDLE and DONE.
- Held outputs (fields, crc_ok_out) change only in DONE.
- Back-to-back strobes on consecutive clocks are supported; no minimum spacing.

Decomposition:
- Shared package rl02_pkg:
  - RL02_CRC_POLY = 16'hA001
  - header field widths/offsets (SECTOR_W=6, HEAD_BIT=6, CYL_LSB=7, CYL_W=9)
  - state encoding localparams
- Sub-module rl02_crc16_serial:
  - inputs: clk_in, rst_in, clear, en, bit.
  - output: 16-bit crc.
  - Reused later by the data-field CRC checker and the write path.

Test Plan:
- Clean header: sector falling edge, 46 zeros, sync 1, word1=16'h01C5 (cyl 3, head 1, sector 5), word2=0, word3=model CRC -> hdr_valid_out 1 cycle after the 48th bit; cyl_out=3, head_out=1, sector_out=5, crc_ok_out=1, no hdr_err_out.
- Corrupt CRC: same stream, word3 bit0 flipped -> hdr_valid_out and hdr_err_out pulse the same cycle; crc_ok_out=0; fields still 3/1/5.
- Short preamble: 10 zeros, 1, then 20 zeros, 1, then header 16'hFFBF (cyl 511, head 0, sector 63) + valid CRC -> first 1 rejected, header decoded; crc_ok_out=1.
- Timeout: sector edge, then 1024 zero strobes with PREAMBLE_MIN unmet never arriving at sync (all 1s alternating every 8 bits) -> hdr_err_out pulse at strobe 1024, busy_out drops, outputs unchanged.
- Abort: new sector edge after 20 of 48 data bits, then a full valid header 16'h0000 -> single hdr_valid_out for the second header only; fields 0/0/0.
- Reset mid-SHIFT: rst_in low for 3 cycles during bit 30 -> all outputs 0 immediately (async); next sector edge plus clean header decodes correctly.
